muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers; sits beside the EX-stage ALU of the pipelined MIPS core.
- Successor to the fixed single-cycle hi/lo enable path: any WIDTH, signed/unsigned multiply and divide, and a busy/done handshake the hazard unit uses to stall.
- Also handles mthi/mtlo writes, and cancel on pipeline flush.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch op with a/b (sampled in IDLE or DONE only)
- op  in  2  muldiv_pkg::op_t: MULT=0, MULTU=1, DIV=2, DIVU=3
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- cancel  in  1  abort in-flight op (EX flush)
- hi_we  in  1  mthi write
- lo_we  in  1  mtlo write
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  high in RUN and FIX
- done  out  1  one-cycle pulse; HI/LO hold the result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset:
  - State IDLE; hi=0, lo=0, busy=0, done=0.
  - Counter and working registers are cleared.
  - Reset mid-operation discards the operation.
- States:
  - IDLE -(start & !cancel)-> RUN.
  - RUN -(k iterations)-> FIX.
  - FIX -> DONE.
  - DONE -> IDLE, or -> RUN if start is accepted in DONE.
- Start edge actions:
  - Latch op.
  - Latch |a| and |b| for MULT/DIV (two's-complement magnitude); raw values for MULTU/DIVU.
  - Record the result signs.
- RUN:
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring, quotient bit per cycle.
  - k = WIDTH iterations.
- FIX:
  - Apply signs.
  - MULT: product negated if sign(a) != sign(b).
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Write HI/LO at the end of FIX.
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: hi = remainder, lo = quotient.
- Latency: done is high during cycle k+2 after the start cycle (34 for WIDTH=32); busy=0 and done=1 in that cycle.
- Divide by zero:
  - Detected at start.
  - Still runs the full latency.
  - Result hi=a, lo=all ones, for both DIV and DIVU.
- DIV most-negative / -1: lo = most-negative value, hi = 0, no trap.
- start while busy: ignored.
- cancel:
  - Valid in any state.
  - Returns to IDLE next cycle; HI/LO unchanged; no done.
  - Wins over a same-cycle start.
- Write priority per edge: reset > cancel > FIX result write > hi_we/lo_we.
  - An mthi/mtlo in the FIX cycle is lost.
  - In other cycles it writes immediately, including while busy; a later completion overwrites it.
- hi_we and lo_we may be asserted together; both take wdata.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- When defined: multiply leaves RUN after any step in which the remaining unshifted multiplier bits are all zero, so k = index of the highest set bit of |b| + 1, with minimum 1.
  - Multiply with b=0 takes k=1.
  - Divide is unaffected.
- When not defined: k = WIDTH always; fixed latency.

Decomposition:
- muldiv_pkg:
  - op_t enum.
  - state_t enum {IDLE, RUN, FIX, DONE}.
  - Helper function is_signed(op_t).
- Sub-module muldiv_step: combinational single iteration (add-shift or subtract-compare), selected by mul/div. Keeps the FSM and register file in muldiv_unit.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 1..33.
- MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=7, b=0 -> hi=0x00000007, lo=0xFFFFFFFF.
- Preload hi=0x11, lo=0x22 via mthi/mtlo; start DIVU; cancel in cycle 10 -> busy=0 in cycle 11, no done, hi/lo stay 0x11/0x22.
  - Then start (accepted) and cancel in the same cycle -> stays IDLE.
- With MULDIV_EARLY_OUT_EN, MULTU a=3, b=1 -> done 3 cycles after start, lo=3, hi=0.
  - Without the macro, the same op -> done at cycle 34.
- Back-to-back: start in the DONE cycle -> accepted, second done exactly 34 cycles later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared types for the iterative multiply/divide unit.
//   op_t    : operation selector driven by the EX stage.
//   state_t : control state of muldiv_unit.
//   is_signed / is_div : small decode helpers used by the unit and its bench.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_signed(input op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div(input op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   Combinational single radix-2 iteration of the multiply/divide datapath.
//   Multiply (is_div=0): acc += b_i[0] ? aux : 0; aux <<= 1; b >>= 1.
//     acc = 2W product accumulator, aux = left-shifting multiplicand,
//     b   = right-shifting multiplier (all zero once no set bits remain).
//   Divide (is_div=1): restoring step on acc = {remainder, dividend/quotient},
//     b = divisor; one quotient bit enters acc[0] per call.
// Ports:
//   is_div        in   select divide step
//   acc_i/acc_o   2W   accumulator in/out
//   aux_i/aux_o   2W   shifted multiplicand in/out (passes through on divide)
//   b_i/b_o       W    multiplier / divisor in/out
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [2*WIDTH-1:0]   aux_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [2*WIDTH-1:0]   aux_o,
    output logic [WIDTH-1:0]     b_o
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign rem     = acc_i[2*WIDTH-1:WIDTH];
    assign quo     = acc_i[WIDTH-1:0];
    // Remainder stays below the divisor, so the shifted partial remainder
    // needs one extra bit and the successful difference fits back in WIDTH.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, b_i};

    always_comb begin
        if (is_div) begin
            aux_o = aux_i;
            b_o   = b_i;
            if (!trial[WIDTH]) begin
                acc_o = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = acc_i + (b_i[0] ? aux_i : '0);
            aux_o = aux_i << 1;
            b_o   = b_i >> 1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative signed/unsigned multiply and divide with architectural HI/LO.
//   Start is accepted in IDLE or DONE; RUN performs k radix-2 steps, FIX applies
//   signs and writes HI/LO, DONE pulses done for one cycle.
//   Optional macro MULDIV_EARLY_OUT_EN: a multiply leaves RUN as soon as the
//   remaining multiplier bits are zero (divide always takes WIDTH steps).
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, op, a, b launch an operation
//   cancel          abort any in-flight operation (pipeline flush)
//   hi_we, lo_we    mthi / mtlo write enables, data on wdata
//   busy            high in RUN and FIX
//   done            one-cycle completion pulse
//   hi, lo          HI / LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] aux_q, aux_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] step_aux;
    logic [WIDTH-1:0]   step_b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div(op_q)),
        .acc_i  (acc_q),
        .aux_i  (aux_q),
        .b_i    (b_q),
        .acc_o  (step_acc),
        .aux_o  (step_aux),
        .b_o    (step_b)
    );

    // Operand magnitudes captured on the start edge.
    logic             sgn_op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign sgn_op = is_signed(op);
    assign mag_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign mag_b  = (sgn_op && b[WIDTH-1]) ? -b : b;

    // Sign fix-up results, consumed in FIX.
    logic               neg_res;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   rem_raw, quo_raw;
    logic [WIDTH-1:0]   rem_s, quo_s;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign neg_res = neg_a_q ^ neg_b_q;
    assign prod_s  = neg_res ? -acc_q : acc_q;
    assign rem_raw = acc_q[2*WIDTH-1:WIDTH];
    assign quo_raw = acc_q[WIDTH-1:0];
    // Remainder follows the dividend; with a zero divisor the restoring loop
    // leaves |a| in the remainder, so this also reproduces hi = a.
    assign rem_s   = neg_a_q ? -rem_raw : rem_raw;
    assign quo_s   = neg_res ? -quo_raw : quo_raw;
    assign res_hi  = is_div(op_q) ? rem_s : prod_s[2*WIDTH-1:WIDTH];
    assign res_lo  = is_div(op_q) ? (div0_q ? '1 : quo_s) : prod_s[WIDTH-1:0];

    logic run_last;

    always_comb begin
        // NOTE: every _d defaults to its _q so no path through this block
        // leaves a variable unassigned and infers a latch.
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        aux_d   = aux_q;
        b_d     = b_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        run_last = (cnt_q == LAST_CNT);
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div(op_q) && (step_b == '0)) begin
            run_last = 1'b1;
        end
`endif

        // NOTE: cancel outranks start and the FIX write, and also drops any
        // same-cycle mthi/mtlo, so a flushed instruction leaves no trace.
        if (cancel) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        state_d = RUN;
                        op_d    = op;
                        cnt_d   = '0;
                        neg_a_d = sgn_op & a[WIDTH-1];
                        neg_b_d = sgn_op & b[WIDTH-1];
                        div0_d  = is_div(op) && (b == '0);
                        b_d     = mag_b;
                        if (is_div(op)) begin
                            acc_d = {{WIDTH{1'b0}}, mag_a};
                            aux_d = '0;
                        end else begin
                            acc_d = '0;
                            aux_d = {{WIDTH{1'b0}}, mag_a};
                        end
                    end
                end
                RUN: begin
                    acc_d = step_acc;
                    aux_d = step_aux;
                    b_d   = step_b;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (run_last) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase

            // mthi/mtlo write immediately except in FIX, where the result wins.
            if (state_q != FIX) begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
            end
        end

        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: working registers are cleared on reset too, so a reset in the
        // middle of an operation leaves no stale partial result behind.
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            aux_q   <= '0;
            b_q     <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            aux_q   <= aux_d;
            b_q     <= b_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit at WIDTH=32. Directed cases plus
//   randomized operations checked against an arithmetic reference model.
//   Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    op_t          op;
    logic [W-1:0] a, b;
    logic         cancel;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the arithmetic definitions.
    task automatic model(input op_t o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         output logic [W-1:0] ehi, output logic [W-1:0] elo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(ai));
        sb = longint'($signed(bi));
        case (o)
            MULT:  begin p = 64'(sa * sb);               ehi = p[63:32]; elo = p[31:0]; end
            MULTU: begin p = {32'h0, ai} * {32'h0, bi};  ehi = p[63:32]; elo = p[31:0]; end
            DIV: begin
                if (bi == 0) begin ehi = ai; elo = '1; end
                else begin
                    q = sa / sb; r = sa % sb;
                    p = 64'(q); elo = p[31:0];
                    p = 64'(r); ehi = p[31:0];
                end
            end
            default: begin
                if (bi == 0) begin ehi = ai; elo = '1; end
                else begin ehi = ai % bi; elo = ai / bi; end
            end
        endcase
    endtask

    // Cycle (counted from the start cycle) in which done is expected.
    function automatic int exp_latency(input op_t o, input logic [W-1:0] bi);
        int k;
        logic [W-1:0] m;
        k = W;
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div(o)) begin
            m = (is_signed(o) && bi[W-1]) ? -bi : bi;
            k = 1;
            for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
        end
`else
        m = bi;
`endif
        return k + 2;
    endfunction

    task automatic do_op(input string tag, input op_t o, input logic [W-1:0] ai, input logic [W-1:0] bi);
        int           cyc;
        bit           busy_ok;
        logic [W-1:0] ehi, elo;
        model(o, ai, bi, ehi, elo);
        @(negedge clk);
        start = 1'b1; op = o; a = ai; b = bi;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(exp_latency(o, bi)));
        check({tag, " busy_run"}, 64'(busy_ok), 64'(1));
        check({tag, " busy_done"}, 64'(busy), 64'(0));
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
    endtask

    task automatic watch_no_done(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check({tag, " quiet"}, 64'(seen), 64'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           sel;
        reset = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        @(negedge clk); reset = 1'b0;

        // Directed arithmetic; consecutive calls start in the DONE cycle.
        do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd5);
        do_op("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2);
        do_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_zero", DIVU,  32'd7,         32'd0);
        do_op("div_zero",  DIV,   32'hFFFF_FFF0, 32'd0);
        do_op("multu_3x1", MULTU, 32'd3,         32'd1);
        do_op("mult_b0",   MULT,  32'h1234_5678, 32'd0);
        check("explicit hi", 64'(hi), 64'(0));
        check("explicit lo", 64'(lo), 64'(0));
        @(posedge clk); #1;
        check("done pulse", 64'(done), 64'(0));

        // mthi/mtlo preload, then cancel a DIVU in cycle 10.
        @(negedge clk); hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(negedge clk); lo_we = 1'b0;
        check("mthi", 64'(hi), 64'(32'h11));
        check("mtlo", 64'(lo), 64'(32'h22));
        start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("cancel busy_c10", 64'(busy), 64'(1));
        @(negedge clk); cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        check("cancel busy_c11", 64'(busy), 64'(0));
        check("cancel done_c11", 64'(done), 64'(0));
        watch_no_done("cancel", 40);
        check("cancel hi", 64'(hi), 64'(32'h11));
        check("cancel lo", 64'(lo), 64'(32'h22));

        // start and cancel together: stays IDLE.
        @(negedge clk); start = 1'b1; cancel = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
        @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
        check("start_cancel busy", 64'(busy), 64'(0));
        watch_no_done("start_cancel", 40);
        check("start_cancel hi", 64'(hi), 64'(32'h11));

        // mthi while busy lands; mtlo in FIX is lost; result overwrites.
        @(negedge clk); start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk); hi_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1; hi_we = 1'b0;
        check("mthi_busy hi", 64'(hi), 64'(32'hABCD));
        check("mthi_busy busy", 64'(busy), 64'(1));
        repeat (27) begin @(posedge clk); #1; end
        check("fix busy", 64'(busy), 64'(1));
        @(negedge clk); lo_we = 1'b1; wdata = 32'h5555;
        @(posedge clk); #1; lo_we = 1'b0;
        check("fix done", 64'(done), 64'(1));
        check("fix hi", 64'(hi), 64'(2));
        check("fix lo", 64'(lo), 64'(14));

        // Randomized operations with occasional idle gaps.
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 5);
            ra = $urandom;
            case (sel)
                0: rb = '0;
                1: rb = W'($urandom_range(0, 15));
                2: begin ra = 32'h8000_0000; rb = '1; end
                default: rb = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op($sformatf("rand%0d", i), op_t'($urandom_range(0, 3)), ra, rb);
        end

        // Reset mid-operation discards it.
        @(negedge clk); start = 1'b1; op = MULT; a = 32'd77; b = 32'd88;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset hi", 64'(hi), 64'(0));
        check("midreset lo", 64'(lo), 64'(0));
        @(negedge clk); reset = 1'b0;
        watch_no_done("midreset", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
